draw_maze_from_ram: RTL and testbench
=====================================

DRAW_MAZE_FROM_RAM -- requirements
Module: draw_maze_from_ram

Interface
REQ-001: Parameter CELL_PX, default 3; pixel edge length of one maze cell, legal range 1..3.
REQ-002: Parameter X_ORIGIN, default 32; screen x of the top-left pixel of cell (0,0).
REQ-003: Parameter Y_ORIGIN, default 12; screen y of the top-left pixel of cell (0,0).
REQ-004: clk  input  1  system clock; all state updates on posedge.
REQ-005: resetn  input  1  asynchronous, active-low reset.
REQ-006: start  input  1  request one full-maze redraw; sampled only in IDLE.
REQ-007: address  output  10  maze RAM read address, {cell_y[4:0], cell_x[4:0]}.
REQ-008: ram_q  input  3  maze RAM read data, valid one cycle after address is presented.
REQ-009: x  output  8  VGA pixel x.
REQ-010: y  output  7  VGA pixel y.
REQ-011: colour  output  3  VGA pixel colour.
REQ-012: plot  output  1  VGA write strobe; x, y and colour are valid when it is high.
REQ-013: busy  output  1  high from the cycle after start is accepted until DONE.
REQ-014: done  output  1  single-cycle pulse when the redraw completes.

Function
REQ-015: FSM states: IDLE, FETCH, LATCH, PAINT, DONE.
- IDLE->FETCH on start=1, with address=0.
- FETCH->LATCH unconditionally.
- LATCH->PAINT; colour register <= ram_q; pixel counters px, py <= 0.
- DONE->IDLE unconditionally.
REQ-016: In PAINT, plot=1 every cycle, with x=X_ORIGIN+cell_x*CELL_PX+px and y=Y_ORIGIN+cell_y*CELL_PX+py.
- px increments 0..CELL_PX-1; on wrap, py increments.
- PAINT lasts exactly CELL_PX*CELL_PX cycles per cell.
REQ-017: On the last PAINT pixel:
- if address==1023, go to DONE;
- otherwise address <= address+1 (cell_x wraps 31->0 and carries into cell_y) and go to FETCH.
REQ-018: address is stable throughout FETCH, LATCH and PAINT; it changes only in the IDLE->FETCH transition or on the last PAINT pixel.
REQ-019: Latency: the first plot occurs 3 cycles after the start-sampling edge. With defaults, a full redraw is 1024*11=11264 cycles from FETCH entry to DONE entry.
REQ-020: start while busy is ignored, with no queuing.
REQ-021: start held high through DONE retriggers a new redraw from IDLE on the following cycle.
REQ-022: done=1 only in DONE; busy=0 in IDLE and DONE.
REQ-023: plot=0 in every state other than PAINT; x, y and colour hold their last values when plot=0.
REQ-024: Coordinate arithmetic is unsigned. With the parameters in range, x stays <=159 and y <=119; no clipping logic.

Reset
REQ-025: resetn=0 forces, asynchronously, from any state including mid-PAINT:
- state=IDLE;
- address=0, x=0, y=0, colour=0;
- plot=0, busy=0, done=0;
- px=0, py=0.
REQ-026: After reset release, no plot occurs until a new start is accepted.

Configuration
REQ-027: Macro DRAW_MAZE_SKIP_BLACK_EN.
- Defined: in LATCH, if ram_q==0, skip PAINT and advance as at the end of PAINT (REQ-017); black cells cost 2 cycles and produce no plot.
- Undefined: every cell is painted, including black cells.

Structure
REQ-028: Shared package maze_pkg holds:
- GRID_DIM=32, ADDR_W=10, COLOUR_W=3, VGA_X_W=8, VGA_Y_W=7;
- the FSM state encoding.
REQ-029: One sub-module, cell_pixel_counter: px/py counter with clear, enable and last-pixel flag, parameterised by CELL_PX.

Verification
REQ-030: Reset, then start pulse; RAM model returns 3'b100 for all cells.
-> First plot at x=32, y=12, colour=4, 3 cycles after start is sampled.
-> 9216 plots total; done pulses once, 11264 cycles after FETCH entry.
REQ-031: Cell address 33 (cell_x=1, cell_y=1) holds 3'b010.
-> Exactly 9 plots with colour=2 at x 35..37, y 15..17.
REQ-032: start pulsed again mid-redraw at address 500.
-> Ignored; address sequence and final plot count are unchanged.
REQ-033: resetn asserted during PAINT of cell 200.
-> Same cycle: plot=0, busy=0, address=0; no plots after release until a new start.
REQ-034: With DRAW_MAZE_SKIP_BLACK_EN; RAM all zero except address 1023=3'b111.
-> 9 plots only, at x 125..127, y 105..107.
-> done after 1023*2+11 cycles.
REQ-035: start held high continuously.
-> done pulses, one IDLE cycle follows, then FETCH with address=0 again.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared grid/VGA widths and FSM encoding for the maze redraw block
package maze_pkg;
  localparam int GRID_DIM = 32;
  localparam int ADDR_W   = 10;
  localparam int COLOUR_W = 3;
  localparam int VGA_X_W  = 8;
  localparam int VGA_Y_W  = 7;
  localparam int CELL_W   = 5;
  localparam int PIX_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_PAINT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/cell_pixel_counter.sv
// rtl/cell_pixel_counter.sv - px/py raster counter over one CELL_PX x CELL_PX maze cell
module cell_pixel_counter
  import maze_pkg::*;
#(
  parameter int CELL_PX = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  output logic [PIX_W-1:0] px,
  output logic [PIX_W-1:0] py,
  output logic             last
);
  localparam logic [PIX_W-1:0] LAST_IDX = PIX_W'(CELL_PX - 1);

  logic [PIX_W-1:0] px_q, px_d;
  logic [PIX_W-1:0] py_q, py_d;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clr) begin
      px_d = '0;
      py_d = '0;
    end else if (en) begin
      if (px_q == LAST_IDX) begin
        px_d = '0;
        py_d = (py_q == LAST_IDX) ? '0 : py_q + PIX_W'(1);
      end else begin
        px_d = px_q + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  assign last = (px_q == LAST_IDX) && (py_q == LAST_IDX);
endmodule

// File: rtl/draw_maze_from_ram.sv
// rtl/draw_maze_from_ram.sv - walks the 32x32 maze RAM and plots each cell as a pixel block
// Optional DRAW_MAZE_SKIP_BLACK_EN: black cells are skipped without plotting.
module draw_maze_from_ram
  import maze_pkg::*;
#(
  parameter int CELL_PX  = 3,
  parameter int X_ORIGIN = 32,
  parameter int Y_ORIGIN = 12
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  output logic [ADDR_W-1:0]   address,
  input  logic [COLOUR_W-1:0] ram_q,
  output logic [VGA_X_W-1:0]  x,
  output logic [VGA_Y_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  localparam logic [VGA_X_W-1:0] XO  = VGA_X_W'(X_ORIGIN);
  localparam logic [VGA_Y_W-1:0] YO  = VGA_Y_W'(Y_ORIGIN);
  localparam logic [VGA_X_W-1:0] CPX = VGA_X_W'(CELL_PX);
  localparam logic [VGA_Y_W-1:0] CPY = VGA_Y_W'(CELL_PX);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [COLOUR_W-1:0] cell_colour_q, cell_colour_d;
  logic [VGA_X_W-1:0]  x_q, x_d;
  logic [VGA_Y_W-1:0]  y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic [PIX_W-1:0]    px, py;
  logic                last_px, cnt_clr, cnt_en, advance;
  logic [CELL_W-1:0]   cell_x, cell_y;
  logic [VGA_X_W-1:0]  x_pix;
  logic [VGA_Y_W-1:0]  y_pix;

  cell_pixel_counter #(.CELL_PX(CELL_PX)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .px     (px),
    .py     (py),
    .last   (last_px)
  );

  assign cell_x = address_q[CELL_W-1:0];
  assign cell_y = address_q[ADDR_W-1:CELL_W];
  assign x_pix  = XO + VGA_X_W'(cell_x) * CPX + VGA_X_W'(px);
  assign y_pix  = YO + VGA_Y_W'(cell_y) * CPY + VGA_Y_W'(py);

  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    cell_colour_d = cell_colour_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    plot          = 1'b0;
    advance       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          address_d = '0;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        cell_colour_d = ram_q;
        cnt_clr       = 1'b1;
        state_d       = ST_PAINT;
`ifdef DRAW_MAZE_SKIP_BLACK_EN
        if (ram_q == '0) advance = 1'b1;
`endif
      end
      ST_PAINT: begin
        plot   = 1'b1;
        cnt_en = 1'b1;
        if (last_px) advance = 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Cell finished (painted or skipped): step raster order or finish after cell 1023
    if (advance) begin
      if (&address_q) begin
        state_d = ST_DONE;
      end else begin
        address_d = address_q + ADDR_W'(1);
        state_d   = ST_FETCH;
      end
    end
    x_d      = plot ? x_pix : x_q;
    y_d      = plot ? y_pix : y_q;
    colour_d = plot ? cell_colour_q : colour_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      address_q     <= '0;
      cell_colour_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      cell_colour_q <= cell_colour_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
    end
  end

  // Pixel outputs are live during PAINT and hold the last plotted pixel otherwise
  assign address = address_q;
  assign x       = plot ? x_pix : x_q;
  assign y       = plot ? y_pix : y_q;
  assign colour  = plot ? cell_colour_q : colour_q;
  assign busy    = (state_q == ST_FETCH) || (state_q == ST_LATCH) || (state_q == ST_PAINT);
  assign done    = (state_q == ST_DONE);
endmodule

// File: tb/tb_draw_maze_from_ram.sv
// tb/tb_draw_maze_from_ram.sv - randomized maze redraws checked against a per-cell pixel model
module tb_draw_maze_from_ram;
  localparam int CP = 3;
  localparam int XO = 32;
  localparam int YO = 12;

  logic       clk = 1'b0;
  logic       resetn, start;
  logic [9:0] address;
  logic [2:0] ram_q;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  logic [2:0]  mem [0:1023];
  logic [27:0] expq[$];
  int n_cmp = 0, n_bad = 0;
  int exp_cycles, exp_plots, plots, c2_plots, done_pulses, n, waitc;
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [2:0] last_c;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[address];

  draw_maze_from_ram #(.CELL_PX(CP), .X_ORIGIN(XO), .Y_ORIGIN(YO)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .address (address),
    .ram_q   (ram_q),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .plot    (plot),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit painted(input logic [2:0] c);
`ifdef DRAW_MAZE_SKIP_BLACK_EN
    return c != 3'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Expected pixel stream and cycle cost, cell by cell in raster order
  task automatic build_expect();
    exp_cycles = 0;
    expq.delete();
    for (int a = 0; a < 1024; a++) begin
      if (painted(mem[a])) begin
        exp_cycles += 2 + CP * CP;
        for (int py = 0; py < CP; py++)
          for (int px = 0; px < CP; px++)
            expq.push_back({10'(a), 8'(XO + (a % 32) * CP + px), 7'(YO + (a / 32) * CP + py), mem[a]});
      end else begin
        exp_cycles += 2;
      end
    end
    exp_plots = expq.size();
  endtask

  task automatic fill_random();
    for (int a = 0; a < 1024; a++) mem[a] = 3'($urandom_range(0, 7));
  endtask

  initial begin : compare
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        last_x = '0; last_y = '0; last_c = '0;
      end else begin
        if (plot) begin
          plots++;
          if (colour == 3'd2) c2_plots++;
          check("plot_expected", 32'(plot), 32'(expq.size() != 0));
          if (expq.size() != 0) begin
            e = expq.pop_front();
            check("pixel", {4'b0, address, x, y, colour}, {4'b0, e});
          end
          last_x = x; last_y = y; last_c = colour;
        end else begin
          check("hold", {13'b0, x, y, colour}, {13'b0, last_x, last_y, last_c});
        end
        if (done) begin
          done_pulses++;
          check("done_not_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic run_redraw(input bit hold, input bit literal, input bit inject);
    int inj;
    inj = 0;
    plots = 0; c2_plots = 0; done_pulses = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20000) begin
      n++;
      if (literal) begin
        if (n == 1 || n == 2) check("no_early_plot", 32'(plot), 32'd0);
        if (n == 3) check("first_plot", {13'b0, plot, x, y, colour}, {13'b0, 1'b1, 8'd32, 7'd12, 3'd4});
      end
      if (inject) begin
        if (inj == 0 && address == 10'd500) begin start = 1'b1; inj = 1; end
        else if (inj == 1) begin start = 1'b0; inj = 2; end
      end
      @(negedge clk);
    end
    check("redraw_cycles", n, exp_cycles);
    check("queue_drained", expq.size(), 0);
  endtask

  task automatic reset_pulse();
    start = 1'b0;
    #2 resetn = 1'b0;
    expq.delete();
    @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_address", 32'(address), 0);
    check("rst_xyc", {13'b0, x, y, colour}, 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    #2 resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_busy", {30'b0, busy, plot}, 0);

    // All cells colour 4, cell 33 colour 2, plus an ignored start at address 500
    for (int a = 0; a < 1024; a++) mem[a] = 3'd4;
    mem[33] = 3'd2;
    build_expect();
    run_redraw(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("idle_after_done", {30'b0, busy, done}, 0);
    repeat (2) @(negedge clk);
    check("plots_total_A", plots, 9216);
    check("colour2_plots", c2_plots, 9);
    check("done_once_A", done_pulses, 1);
    check("cycles_A_literal", n, 11264);

    // Random maze contents
    fill_random();
    build_expect();
    run_redraw(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("plots_total_B", plots, exp_plots);
    check("done_once_B", done_pulses, 1);

    // Reset in the middle of painting cell 200
    fill_random();
    mem[200] = 3'd5;
    build_expect();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waitc = 0;
    while (!(address == 10'd200 && plot) && waitc < 5000) begin
      waitc++;
      @(negedge clk);
    end
    check("reached_cell200", 32'(address == 10'd200 && plot), 1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_plot", 32'(plot), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_address", 32'(address), 0);
    check("midrst_xyc", {13'b0, x, y, colour}, 0);
    expq.delete();
    @(negedge clk);
    #2 resetn = 1'b1;
    plots = 0;
    repeat (40) @(negedge clk);
    check("no_plot_after_release", plots, 0);

    // Start held high: done, one IDLE cycle, then FETCH from address 0
    fill_random();
    build_expect();
    run_redraw(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("held_idle", {29'b0, busy, done, plot}, 0);
    @(negedge clk);
    check("held_refetch_busy", 32'(busy), 1);
    check("held_refetch_addr", 32'(address), 0);
    reset_pulse();

`ifdef DRAW_MAZE_SKIP_BLACK_EN
    for (int a = 0; a < 1024; a++) mem[a] = 3'd0;
    mem[1023] = 3'd7;
    build_expect();
    run_redraw(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("skip_plots", plots, 9);
    check("skip_cycles_literal", n, 1023 * 2 + 11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
